// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus bundle: two source request channels, the register-file write
// port and the pending-write lookup, as seen between upstream logic and the arbiter.
interface rf_wb_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          s0_valid;
    logic          s0_ready;
    logic [AW-1:0] s0_add;
    logic [DW-1:0] s0_data;
    logic          s1_valid;
    logic          s1_ready;
    logic [AW-1:0] s1_add;
    logic [DW-1:0] s1_data;
    logic          we;
    logic [AW-1:0] w_add;
    logic [DW-1:0] w_data;
    logic [AW-1:0] chk_add1;
    logic [AW-1:0] chk_add2;
    logic          pend1;
    logic          pend2;
    logic          busy;

    modport master (
        output s0_valid, s0_add, s0_data, s1_valid, s1_add, s1_data, chk_add1, chk_add2,
        input  s0_ready, s1_ready, we, w_add, w_data, pend1, pend2, busy
    );

    modport slave (
        input  s0_valid, s0_add, s0_data, s1_valid, s1_add, s1_data, chk_add1, chk_add2,
        output s0_ready, s1_ready, we, w_add, w_data, pend1, pend2, busy
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-source register-file writeback arbiter: per-source in-order queues drained
// round-robin into a registered write port, with pending-write hazard lookup.
module rf_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic           clk,
    input  logic           rst,
    rf_wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] add_mem_q  [2][DEPTH];
    logic [DW-1:0] data_mem_q [2][DEPTH];
    logic [PW-1:0] wr_ptr_q [2];
    logic [PW-1:0] wr_ptr_d [2];
    logic [PW-1:0] rd_ptr_q [2];
    logic [PW-1:0] rd_ptr_d [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic          rr_q, rr_d;
    logic          we_q, we_d;
    logic [AW-1:0] w_add_q, w_add_d;
    logic [DW-1:0] w_data_q, w_data_d;

    logic          in_valid [2];
    logic [AW-1:0] in_add   [2];
    logic [DW-1:0] in_data  [2];
    logic          ready    [2];
    logic          nonempty [2];
    logic          push     [2];
    logic          pop      [2];
    logic          gnt, gnt_src;
    logic          pend1_c, pend2_c;
    logic [PW-1:0] off;

    always_comb begin
        in_valid[0] = bus.s0_valid;
        in_add[0]   = bus.s0_add;
        in_data[0]  = bus.s0_data;
        in_valid[1] = bus.s1_valid;
        in_add[1]   = bus.s1_add;
        in_data[1]  = bus.s1_data;

        for (int s = 0; s < 2; s++) begin
            ready[s]    = (cnt_q[s] != CW'(DEPTH));
            nonempty[s] = (cnt_q[s] != '0);
            // Writes to x0 are accepted but never queued.
            push[s]     = in_valid[s] & ready[s] & (in_add[s] != '0);
        end

        // rr_q names the source that wins the next tie.
        gnt     = nonempty[0] | nonempty[1];
        gnt_src = (nonempty[0] & nonempty[1]) ? rr_q : nonempty[1];
        rr_d    = gnt ? ~gnt_src : rr_q;

        for (int s = 0; s < 2; s++) begin
            pop[s]      = gnt & (gnt_src == 1'(s));
            wr_ptr_d[s] = wr_ptr_q[s] + PW'(push[s]);
            rd_ptr_d[s] = rd_ptr_q[s] + PW'(pop[s]);
            cnt_d[s]    = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
        end

        we_d     = gnt;
        w_add_d  = gnt ? add_mem_q[gnt_src][rd_ptr_q[gnt_src]]  : w_add_q;
        w_data_d = gnt ? data_mem_q[gnt_src][rd_ptr_q[gnt_src]] : w_data_q;
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        pend1_c = 1'b0;
        pend2_c = 1'b0;
        off     = '0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                off = PW'(i) - rd_ptr_q[s];
                if ({1'b0, off} < cnt_q[s]) begin
                    if (add_mem_q[s][i] == bus.chk_add1) pend1_c = 1'b1;
                    if (add_mem_q[s][i] == bus.chk_add2) pend2_c = 1'b1;
                end
            end
        end
        if (we_q && (w_add_q == bus.chk_add1)) pend1_c = 1'b1;
        if (we_q && (w_add_q == bus.chk_add2)) pend2_c = 1'b1;
        if (bus.chk_add1 == '0) pend1_c = 1'b0;
        if (bus.chk_add2 == '0) pend2_c = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                cnt_q[s]    <= '0;
            end
            rr_q     <= 1'b0;
            we_q     <= 1'b0;
            w_add_q  <= '0;
            w_data_q <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= wr_ptr_d[s];
                rd_ptr_q[s] <= rd_ptr_d[s];
                cnt_q[s]    <= cnt_d[s];
            end
            rr_q     <= rr_d;
            we_q     <= we_d;
            w_add_q  <= w_add_d;
            w_data_q <= w_data_d;
        end
    end

    // Queue storage needs no reset; the counts decide which entries are live.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                add_mem_q[s][wr_ptr_q[s]]  <= in_add[s];
                data_mem_q[s][wr_ptr_q[s]] <= in_data[s];
            end
        end
    end

    assign bus.s0_ready = ready[0];
    assign bus.s1_ready = ready[1];
    assign bus.we       = we_q;
    assign bus.w_add    = w_add_q;
    assign bus.w_data   = w_data_q;
    assign bus.pend1    = pend1_c;
    assign bus.pend2    = pend2_c;
    assign bus.busy     = (cnt_q[0] != '0) | (cnt_q[1] != '0) | we_q;
endmodule
